// File: rtl/ldpc_output_serializer.sv
// LDPC output serializer.
// Watches the decoder hard-decision vector P after a start pulse. The vector is
// captured when it has stayed unchanged for STABLE_CNT cycles (converged) or when
// MAX_CYCLES monitoring cycles have elapsed (timeout). The captured codeword is
// then streamed out as N_BITS/WORD_W words over a valid/ready handshake, with
// bit 0 of P in the MSB of the first word.
module ldpc_output_serializer #(
    parameter int N_BITS     = 576,
    parameter int WORD_W     = 32,
    parameter int STABLE_CNT = 3,
    parameter int MAX_CYCLES = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [0:N_BITS-1]   P,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic                converged,
    output logic                frame_done
);

    localparam int N_WORDS = N_BITS / WORD_W;
    localparam int CYC_W   = $clog2(MAX_CYCLES + 1);
    localparam int STB_W   = $clog2(STABLE_CNT + 1);
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [STB_W-1:0] STB_LIMIT = STB_W'(STABLE_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, MONITOR, SEND} state_t;

    state_t              state_reg;
    logic [0:N_BITS-1]   prev_p_reg;
    logic [0:N_BITS-1]   buf_reg;
    logic [CYC_W-1:0]    cycle_cnt_reg;
    logic [STB_W-1:0]    stable_cnt_reg;
    logic [IDX_W-1:0]    word_idx_reg;
    logic [WORD_W-1:0]   dout_reg;
    logic                dout_valid_reg;
    logic                dout_last_reg;
    logic                converged_reg;
    logic                frame_done_reg;

    logic [CYC_W-1:0]    cycle_cnt_next;
    logic [STB_W-1:0]    stable_cnt_next;
    logic                conv_hit;
    logic                timeout_hit;
    logic                is_last;
    logic [IDX_W-1:0]    next_idx;

    // Word view of the captured buffer; lowest bit index lands in the word MSB.
    logic [WORD_W-1:0]   buf_words [N_WORDS];

    generate
        for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
            assign buf_words[gi] = buf_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Next-count values and capture decisions for the current MONITOR cycle.
    always_comb begin
        cycle_cnt_next  = cycle_cnt_reg + CYC_W'(1);
        stable_cnt_next = (P == prev_p_reg) ? stable_cnt_reg + STB_W'(1) : '0;
        conv_hit        = (stable_cnt_next == STB_LIMIT);
        timeout_hit     = (cycle_cnt_next == CYC_LIMIT);
        is_last         = (word_idx_reg == LAST_IDX);
        next_idx        = is_last ? word_idx_reg : word_idx_reg + IDX_W'(1);
    end

    // Control FSM with registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cycle_cnt_reg  <= '0;
            stable_cnt_reg <= '0;
            word_idx_reg   <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            converged_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        prev_p_reg     <= P;
                        cycle_cnt_reg  <= '0;
                        stable_cnt_reg <= '0;
                        converged_reg  <= 1'b0;
                        state_reg      <= MONITOR;
                    end
                end
                MONITOR: begin
                    cycle_cnt_reg  <= cycle_cnt_next;
                    stable_cnt_reg <= stable_cnt_next;
                    prev_p_reg     <= P;
                    if (conv_hit || timeout_hit) begin
                        // Convergence wins when both fire on the same cycle.
                        buf_reg        <= P;
                        converged_reg  <= conv_hit;
                        word_idx_reg   <= '0;
                        dout_reg       <= P[0 +: WORD_W];
                        dout_valid_reg <= 1'b1;
                        dout_last_reg  <= (N_WORDS == 1);
                        state_reg      <= SEND;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        if (is_last) begin
                            word_idx_reg   <= '0;
                            dout_reg       <= '0;
                            dout_valid_reg <= 1'b0;
                            dout_last_reg  <= 1'b0;
                            frame_done_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            word_idx_reg  <= next_idx;
                            dout_reg      <= buf_words[next_idx];
                            dout_last_reg <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_last  = dout_last_reg;
    assign busy       = (state_reg != IDLE);
    assign converged  = converged_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ldpc_output_serializer.sv
// Directed bench for ldpc_output_serializer at default parameters
// (576-bit codeword, 18 x 32-bit words, STABLE_CNT=3, MAX_CYCLES=40).
module tb_ldpc_output_serializer;

    localparam int N_BITS  = 576;
    localparam int WORD_W  = 32;
    localparam int N_WORDS = 18;

    logic                clk;
    logic                reset;
    logic                start;
    logic [0:N_BITS-1]   P;
    logic [WORD_W-1:0]   dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                dout_last;
    logic                busy;
    logic                converged;
    logic                frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_w [N_WORDS];

    ldpc_output_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .P          (P),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .converged  (converged),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build P so that word k of the frame equals exp_w[k] (MSB = lowest bit index).
    task automatic build_p();
        for (int k = 0; k < N_WORDS; k++)
            for (int b = 0; b < WORD_W; b++)
                P[k*WORD_W + b] = exp_w[k][WORD_W-1-b];
    endtask

    // Start a frame with P held constant; capture is expected on the 3rd MONITOR cycle.
    // A start pulse is injected on MONITOR cycle 2 and must be ignored.
    task automatic start_converging(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("%s_wait%0d", name, i), 32'(dout_valid), 32'd0);
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        check({name, "_cap_valid"}, 32'(dout_valid), 32'd1);
        check({name, "_converged"}, 32'(converged), 32'd1);
    endtask

    // Alternate P between all-1 and all-0 every cycle; from hold_from on keep P fixed.
    task automatic run_stream(input int hold_from, input string name);
        P = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (hold_from == 0 || i <= hold_from)
                P = (i % 2 == 0) ? '1 : '0;
            if (i == 40)
                check({name, "_pre_cap_valid"}, 32'(dout_valid), 32'd0);
            tick();
        end
        check({name, "_cap_valid"}, 32'(dout_valid), 32'd1);
    endtask

    // Drain words, comparing each transfer to exp_w. Optional stall of stall_len
    // cycles while word stall_at is presented (with a stray start mid-stall);
    // stop_after>0 returns once that many words have transferred.
    task automatic collect(input int stall_at, input int stall_len, input int stop_after,
                           input string name);
        int  n       = 0;
        int  stalled = 0;
        int  cyc     = 0;
        bit  done    = 0;
        bit  was_last;
        while (!done && cyc < 300) begin
            was_last = 0;
            if (stop_after > 0 && n == stop_after) begin
                done = 1;
            end else begin
                if (n == stall_at && stalled < stall_len) begin
                    stalled++;
                    dout_ready = 1'b0;
                    start      = (stalled == 2);
                    check($sformatf("%s_stall%0d_valid", name, stalled), 32'(dout_valid), 32'd1);
                    check($sformatf("%s_stall%0d_dout", name, stalled), dout, exp_w[n]);
                end else begin
                    dout_ready = 1'b1;
                    start      = 1'b0;
                end
                if (dout_valid && dout_ready) begin
                    check($sformatf("%s_w%0d", name, n), dout, exp_w[n]);
                    check($sformatf("%s_last%0d", name, n), 32'(dout_last), 32'(n == N_WORDS-1));
                    was_last = (n == N_WORDS-1);
                    n++;
                end
                tick();
                cyc++;
                if (was_last) begin
                    check({name, "_frame_done"}, 32'(frame_done), 32'd1);
                    check({name, "_valid_drop"}, 32'(dout_valid), 32'd0);
                    check({name, "_idle"}, 32'(busy), 32'd0);
                    done = 1;
                end
            end
        end
        start      = 1'b0;
        dout_ready = 1'b1;
        check({name, "_xfers"}, 32'(n), (stop_after > 0) ? 32'(stop_after) : 32'(N_WORDS));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        dout_ready = 1'b1;
        P          = '0;
        tick();
        tick();
        check("rst_dout", dout, 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_conv", 32'(converged), 32'd0);
        check("rst_fdone", 32'(frame_done), 32'd0);
        reset = 1'b0;
        tick();

        // Convergence on all-zero P
        for (int k = 0; k < N_WORDS; k++) exp_w[k] = 32'h0;
        build_p();
        start_converging("conv");
        collect(-1, 0, 0, "conv");
        tick();
        check("conv_fdone_pulse", 32'(frame_done), 32'd0);
        check("conv_hold", 32'(converged), 32'd1);

        // Bit ordering: only P[0] and P[575] set
        P = '0;
        P[0] = 1'b1;
        P[N_BITS-1] = 1'b1;
        for (int k = 0; k < N_WORDS; k++) exp_w[k] = 32'h0;
        exp_w[0]  = 32'h80000000;
        exp_w[17] = 32'h00000001;
        start_converging("order");
        collect(-1, 0, 0, "order");

        // Timeout: alternating P, captured value is all-ones from cycle 40
        run_stream(0, "tmo");
        check("tmo_converged", 32'(converged), 32'd0);
        P = '0;  // later P changes must not reach the buffer
        for (int k = 0; k < N_WORDS; k++) exp_w[k] = 32'hFFFFFFFF;
        collect(-1, 0, 0, "tmo");
        check("tmo_conv_hold", 32'(converged), 32'd0);

        // Convergence and timeout on the same cycle: convergence wins
        run_stream(37, "prio");
        check("prio_converged", 32'(converged), 32'd1);
        for (int k = 0; k < N_WORDS; k++) exp_w[k] = 32'h0;
        collect(-1, 0, 0, "prio");

        // Backpressure on word 4 with a stray start during SEND
        for (int k = 0; k < N_WORDS; k++) exp_w[k] = {16'hC0DE, 8'(k), 8'(~k)};
        build_p();
        start_converging("bp");
        collect(4, 5, 0, "bp");

        // Reset after word 7 is transferred, then a full frame
        start_converging("rs");
        collect(-1, 0, 8, "rs");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_dout", dout, 32'd0);
        check("rs_valid", 32'(dout_valid), 32'd0);
        check("rs_last", 32'(dout_last), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_conv", 32'(converged), 32'd0);
        start_converging("rs2");
        collect(-1, 0, 0, "rs2");

        // Reset has priority over start
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rprio_busy", 32'(busy), 32'd0);
        tick();
        check("rprio_busy2", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ldpc_output_serializer.md
LDPC_OUTPUT_SERIALIZER -- requirements
Module: ldpc_output_serializer

Interface
REQ-001 Parameter N_BITS, default 576, SHALL be the codeword length in bits (hard decisions from the decoder).
REQ-002 Parameter WORD_W, default 32, SHALL be the output word width; N_BITS SHALL be a multiple of WORD_W (18 words at defaults).
REQ-003 Parameter STABLE_CNT, default 3, SHALL be the number of consecutive unchanged-P cycles that declares convergence.
REQ-004 Parameter MAX_CYCLES, default 40, SHALL be the monitoring cycle limit before forced capture.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 start  input  1  SHALL be a single-cycle pulse marking the start of a new decode frame.
REQ-008 P  input  [0:N_BITS-1]  SHALL carry the decoder hard-decision vector, bit 0 first.
REQ-009 dout  output  WORD_W  SHALL carry the current output word.
REQ-010 dout_valid  output  1  SHALL flag dout as valid.
REQ-011 dout_ready  input  1  SHALL be the consumer's acceptance signal.
REQ-012 dout_last  output  1  SHALL flag the final word of a frame.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 converged  output  1  SHALL report whether the last frame ended by convergence (1) or by timeout (0).
REQ-015 frame_done  output  1  SHALL pulse for one cycle after the last word is accepted.

Function
REQ-016 States SHALL be IDLE, MONITOR and SEND.
REQ-017 In IDLE, start=1 SHALL load prev_P with P, clear cycle_cnt and stable_cnt, clear converged, and move to MONITOR on the next cycle.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 Each MONITOR cycle SHALL increment cycle_cnt and load prev_P with P.
REQ-020 Each MONITOR cycle SHALL set stable_cnt to stable_cnt+1 if P==prev_P, else to 0.
REQ-021 When the new stable_cnt equals STABLE_CNT, the block SHALL capture the current P into buf, set converged=1, and enter SEND.
REQ-022 Otherwise, when the new cycle_cnt equals MAX_CYCLES, the block SHALL capture the current P into buf, keep converged=0, and enter SEND.
REQ-023 If both REQ-021 and REQ-022 conditions hold in the same cycle, convergence SHALL take priority (converged=1).
REQ-024 In SEND, dout_valid SHALL be 1 and dout SHALL equal word k of buf, k=0..N_BITS/WORD_W-1.
REQ-025 Word k SHALL be P[k*WORD_W .. k*WORD_W+WORD_W-1], with the lowest-index bit placed in dout[WORD_W-1] (MSB).
REQ-026 A word SHALL transfer only on a cycle with dout_valid=1 and dout_ready=1; k SHALL then advance by one.
REQ-027 While dout_valid=1 and dout_ready=0, dout, dout_last and k SHALL hold stable.
REQ-028 dout_last SHALL be 1 only while k = N_BITS/WORD_W-1.
REQ-029 On transfer of the last word, the block SHALL return to IDLE, pulse frame_done for that next cycle, and drop dout_valid.
REQ-030 converged SHALL hold its value from capture until the next accepted start.
REQ-031 P changes after capture SHALL NOT affect buf.
REQ-032 Counter widths SHALL be sized to hold MAX_CYCLES and N_BITS/WORD_W-1 without wrap.

Reset
REQ-033 reset=1 SHALL force IDLE in any state, including mid-MONITOR and mid-SEND, and abandon the frame.
REQ-034 On reset, dout, dout_valid, dout_last, busy, converged and frame_done SHALL all be 0, and all counters SHALL be 0.
REQ-035 reset SHALL take priority over start in the same cycle.

Verification
REQ-036 Convergence case: P=0 constant, start pulse -> converged=1 with capture on the 3rd MONITOR cycle, then 18 words of 32'h00000000, dout_last on the 18th word, then a frame_done pulse.
REQ-037 Timeout case: P toggled between all-0 and all-1 every cycle -> capture on MONITOR cycle 40 with converged=0; word values match the P sampled on that cycle.
REQ-038 Bit ordering: only P[0]=1 and P[575]=1, held constant -> word0=32'h80000000, word17=32'h00000001, all other words 0.
REQ-039 Backpressure: dout_ready low for 5 cycles on word 4 -> dout and dout_valid held and unchanged; exactly 18 transfers occur in total.
REQ-040 Reset mid-SEND after word 7 -> all outputs 0 on the next cycle, state IDLE; a following start runs a complete 18-word frame.
REQ-041 A start during MONITOR or SEND -> no effect on counters, buf or output sequence.
